ram2b_stream_reader: RTL and testbench
======================================

Name: ram2b_stream_reader

Overview:
- Read-side engine for an 8K x 2-bit synchronous dual-port block RAM, driving the RAM's read port.
- Started with an entry address and a byte count. Fetches consecutive 2-bit entries and packs four per byte, LSB first.
- Streams the packed bytes to a sink over a valid/ready interface, with a 2-entry output FIFO to absorb backpressure.
- Used to pull 2bpp bitmap/tile data out of RAM for DMA or display engines.

Parameters:
- ADDR_W, 13, RAM entry address width; addresses wrap modulo 2^ADDR_W.
- CNT_W, 11, byte-count width; 0 encodes 2^CNT_W bytes.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first entry address.
- byte_count  in  CNT_W  number of bytes to produce; 0 means 2048.
- abort  in  1  synchronous cancel of a transfer in progress.
- busy  out  1  high from the start acceptance edge until the done edge.
- done  out  1  one-cycle pulse when the last byte is accepted by the sink.
- ram_en  out  1  read enable to the RAM port (registered).
- ram_addr  out  ADDR_W  read address to the RAM port (registered).
- ram_do  in  2  read data; valid the cycle after ram_en.
- m_data  out  8  output byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  sink accepts the byte when m_valid and m_ready are both high.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0.
  - Internal: FIFO emptied, FSM in IDLE, all counters cleared.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start=1 latches the address and remaining count (0 maps to 2048), sets busy, goes to READ. start is ignored in all other states.
  - READ: issues reads for the remaining bytes. When the last entry read has been issued, goes to DRAIN.
  - DRAIN: waits until the final byte is pushed into the FIFO and the FIFO empties through the sink. On that final handshake edge: done=1 for one cycle, busy=0, return to IDLE.
- Read issue rules:
  - A byte is 4 consecutive reads, one per cycle, never interrupted once begun.
  - The first read of a new byte is issued only when FIFO occupancy plus bytes currently in assembly is less than 2.
  - ram_addr increments by 1 per read and wraps from 2^ADDR_W-1 to 0.
  - ram_en=0 on all cycles without a read.
- Packing:
  - ram_do is captured the cycle after each read into a shift register.
  - Entry k of a byte (k=0..3) lands in bits [2k+1:2k].
  - The byte is pushed into the FIFO on the edge capturing entry 3.
- Latency (start sampled at edge E0):
  - ram_en high in cycles E0–E4.
  - First byte pushed at E5; m_valid high after E5.
  - Peak throughput is 1 byte per 4 cycles.
- FIFO:
  - 2 entries; m_data/m_valid come from the head.
  - Push and pop on the same edge are both honoured.
  - Overflow cannot occur because of the issue rule.
- abort:
  - In READ or DRAIN: on the next edge, ram_en=0, FIFO flushed, m_valid=0, busy=0, return to IDLE. No done pulse. Any read data still in flight is discarded.
  - In IDLE: no effect.
- abort and start together in IDLE: start wins.
- m_data and m_valid stay stable while m_valid=1 and m_ready=0.

Test Plan:
- RAM entries 0..3 = 1,2,3,0; start_addr=0, byte_count=1 → ram_addr 0,1,2,3 on consecutive cycles; m_data=8'h39 with m_valid rising 5 cycles after start; done pulses on the handshake edge; busy is low the next cycle.
- start_addr=8190, byte_count=1 → reads at 8190, 8191, 0, 1; exactly 4 ram_en cycles.
- byte_count=8, m_ready held 0 → exactly 2 bytes buffered, then ram_en stays 0 indefinitely; after m_ready=1, all 8 bytes arrive in order, done fires once, and total ram_en cycles = 32.
- byte_count=0, m_ready=1 → 2048 bytes and 8192 reads; addresses wrap once back to start_addr; single done pulse.
- abort asserted mid-byte on byte 3 of 8 → next cycle ram_en=0, m_valid=0, busy=0, no done; a following start runs cleanly from its new start_addr.
- start pulsed while busy; reset_n pulsed low mid-transfer → the extra start is ignored (read count unchanged); the reset immediately forces all outputs to their reset values and FSM to IDLE.

Source files
------------

// File: rtl/ram2b_stream_reader.sv
// rtl/ram2b_stream_reader.sv - 2-bit RAM read engine packing four entries per byte onto a valid/ready stream
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, start_addr,     transfer request (sampled in IDLE only), first entry address,
//   byte_count, abort      byte count (0 = 2^CNT_W), synchronous cancel
//   busy, done             transfer in progress, one-cycle completion pulse
//   ram_en, ram_addr,      registered RAM read port, data returned one cycle after ram_en
//   ram_do
//   m_data, m_valid,       packed byte stream to the sink (FIFO head)
//   m_ready
module ram2b_stream_reader #(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [1:0]        ram_do,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [CNT_W:0] bytes_left;   // bytes whose first read has not been issued yet
    logic [1:0]     next_k;       // entry index of the next read; 0 means at a byte boundary
    logic [1:0]     ram_k;        // entry index of the read currently on the RAM port
    logic           cap_v;        // ram_do carries valid read data this cycle
    logic [1:0]     cap_k;        // entry index of that data
    logic [5:0]     shift;        // entries 0..2 of the byte being assembled
    logic [1:0]     asm_cnt;      // bytes started but not yet pushed into the FIFO

    logic [7:0]     fifo_mem [0:1];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     fifo_cnt;

    logic           issue, issue_first, flush, done_nxt, push, pop;
    logic [2:0]     occ;
    logic [CNT_W:0] total;

    // 0 in byte_count encodes the full 2^CNT_W range via the extra top bit.
    assign total   = {(byte_count == '0), byte_count};
    assign occ     = {1'b0, fifo_cnt} + {1'b0, asm_cnt};
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign pop     = m_valid && m_ready && !flush;
    assign push    = cap_v && (cap_k == 2'd3) && !flush;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_first = 1'b0;
        flush       = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    issue       = 1'b1;
                    issue_first = 1'b1;
                    state_nxt   = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (next_k != 2'd0) begin
                    // A byte in progress always completes its four reads back to back.
                    issue = 1'b1;
                    if ((next_k == 2'd3) && (bytes_left == '0))
                        state_nxt = S_DRAIN;
                end else if ((bytes_left != '0) && (occ < 3'd2)) begin
                    // Only start a byte when a FIFO slot is guaranteed for it.
                    issue       = 1'b1;
                    issue_first = 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (m_valid && m_ready && (fifo_cnt == 2'd1) && (asm_cnt == 2'd0)) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Read issue and byte assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            bytes_left <= '0;
            next_k     <= 2'd0;
            ram_k      <= 2'd0;
            cap_v      <= 1'b0;
            cap_k      <= 2'd0;
            shift      <= 6'd0;
            asm_cnt    <= 2'd0;
        end else begin
            ram_en <= issue;
            cap_k  <= ram_k;
            // Data returning from reads issued before an abort is dropped.
            cap_v  <= ram_en && !flush;
            if (issue) begin
                ram_addr <= (state == S_IDLE) ? start_addr : ram_addr + 1'b1;
                ram_k    <= next_k;
                next_k   <= next_k + 2'd1;
            end else if (flush) begin
                next_k <= 2'd0;
            end
            if (state == S_IDLE && start)
                bytes_left <= total - 1'b1;
            else if (issue_first)
                bytes_left <= bytes_left - 1'b1;
            if (cap_v && (cap_k != 2'd3))
                shift[2*cap_k +: 2] <= ram_do;
            if (flush)
                asm_cnt <= 2'd0;
            else
                asm_cnt <= asm_cnt + {1'b0, issue_first} - {1'b0, push};
        end
    end

    // Two-entry output FIFO; push and pop may occur on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= 8'd0;
            fifo_mem[1] <= 8'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {ram_do, shift};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram2b_stream_reader.sv
// tb/tb_ram2b_stream_reader.sv - directed self-checking bench for ram2b_stream_reader
module tb_ram2b_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, m_ready;
    logic [12:0] start_addr;
    logic [10:0] byte_count;
    logic        busy, done, ram_en, m_valid;
    logic [12:0] ram_addr;
    logic [1:0]  ram_do = 2'b00;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    ram2b_stream_reader #(.ADDR_W(13), .CNT_W(11)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .byte_count(byte_count), .abort(abort), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_do(ram_do),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    // RAM contents: entries 0..3 = 1,2,3,0; pattern shifts every 4 entries.
    function automatic logic [1:0] ent(int i);
        int v;
        v = (i + 1 + i / 4) % 4;
        return v[1:0];
    endfunction

    function automatic logic [7:0] exp_byte(int a);
        logic [7:0] b;
        for (int j = 0; j < 4; j++) b[2*j +: 2] = ent((a + j) % 8192);
        return b;
    endfunction

    always @(posedge clk) if (ram_en) ram_do <= ent(int'(ram_addr));

    int         en_cnt = 0, done_cnt = 0, rx_n = 0;
    logic [7:0] rx_log [0:8191];

    always @(negedge clk) begin
        if (ram_en) en_cnt <= en_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (m_valid && m_ready) begin
            rx_log[rx_n] <= m_data;
            rx_n         <= rx_n + 1;
        end
    end

    int checks = 0, errors = 0;
    int e0, d0, r0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [12:0] a, input logic [10:0] c);
        start_addr = a;
        byte_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
        tick();
    endtask

    task automatic chk_bytes(input string tag, input int base, input int n, input int addr);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (rx_log[base + i] !== exp_byte((addr + 4 * i) % 8192)) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic snap();
        e0 = en_cnt;
        d0 = done_cnt;
        r0 = rx_n;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        start_addr = '0; byte_count = 11'd1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        reset_n = 1'b1;
        tick();

        // single byte from address 0, latency and done timing
        snap();
        pulse_start(13'd0, 11'd1);
        chk("t1_busy", busy, 1);
        chk("t1_en0", ram_en, 1);
        chk("t1_a0", ram_addr, 0);
        tick(); chk("t1_a1", ram_addr, 1);
        tick(); chk("t1_a2", ram_addr, 2);
        tick(); chk("t1_a3", ram_addr, 3); chk("t1_en3", ram_en, 1);
        tick(); chk("t1_en_off", ram_en, 0); chk("t1_mv_e4", m_valid, 0);
        tick(); chk("t1_mv_e5", m_valid, 1); chk("t1_data", m_data, 8'h39); chk("t1_done_e5", done, 0);
        tick(); chk("t1_done", done, 1); chk("t1_busy_low", busy, 0); chk("t1_mv_low", m_valid, 0);
        tick(); chk("t1_done_pulse", done, 0);
        chk("t1_en_cnt", en_cnt - e0, 4);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // address wrap at the top of the RAM
        snap();
        pulse_start(13'd8190, 11'd1);
        chk("t2_a0", ram_addr, 8190);
        tick(); chk("t2_a1", ram_addr, 8191);
        tick(); chk("t2_a2", ram_addr, 0);
        tick(); chk("t2_a3", ram_addr, 1);
        wait_done(30, "t2_done");
        chk("t2_en_cnt", en_cnt - e0, 4);
        chk("t2_byte", rx_log[r0], 8'h9E);

        // backpressure: only two bytes fetched while the sink stalls
        m_ready = 1'b0;
        snap();
        pulse_start(13'd0, 11'd8);
        for (int i = 0; i < 40; i++) tick();
        chk("t3_en_stall", en_cnt - e0, 8);
        chk("t3_mv_stall", m_valid, 1);
        chk("t3_data_stall", m_data, 8'h39);
        for (int i = 0; i < 40; i++) tick();
        chk("t3_en_stall2", en_cnt - e0, 8);
        chk("t3_data_stable", m_data, 8'h39);
        m_ready = 1'b1;
        wait_done(300, "t3_done");
        chk("t3_en_total", en_cnt - e0, 32);
        chk("t3_rx_n", rx_n - r0, 8);
        chk_bytes("t3_bytes", r0, 8, 0);
        chk("t3_done_cnt", done_cnt - d0, 1);

        // byte_count 0: full 2048-byte transfer wrapping the whole RAM
        snap();
        pulse_start(13'd100, 11'd0);
        wait_done(9000, "t4_done");
        chk("t4_en_total", en_cnt - e0, 8192);
        chk("t4_rx_n", rx_n - r0, 2048);
        chk_bytes("t4_bytes", r0, 2048, 100);
        chk("t4_last_addr", ram_addr, 99);
        chk("t4_done_cnt", done_cnt - d0, 1);

        // abort during the third byte
        snap();
        pulse_start(13'd200, 11'd8);
        for (int i = 0; i < 8; i++) tick();
        chk("t5_en_pre", ram_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_en_off", ram_en, 0);
        chk("t5_mv_off", m_valid, 0);
        chk("t5_busy_off", busy, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_en_cnt", en_cnt - e0, 9);
        chk("t5_rx_n", rx_n - r0, 1);
        chk("t5_byte0", rx_log[r0], exp_byte(200));
        chk("t5_no_done", done_cnt - d0, 0);
        snap();
        pulse_start(13'd300, 11'd2);
        chk("t5_new_addr", ram_addr, 300);
        wait_done(60, "t5_rerun_done");
        chk("t5_rerun_en", en_cnt - e0, 8);
        chk_bytes("t5_rerun_bytes", r0, 2, 300);
        chk("t5_rerun_done_cnt", done_cnt - d0, 1);

        // start while busy is ignored
        snap();
        pulse_start(13'd500, 11'd2);
        tick(); tick(); tick();
        start_addr = 13'd7000;
        byte_count = 11'd5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done(60, "t6_done");
        chk("t6_en_cnt", en_cnt - e0, 8);
        chk_bytes("t6_bytes", r0, 2, 500);
        chk("t6_done_cnt", done_cnt - d0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_idle_en", en_cnt - e0, 8);

        // asynchronous reset mid-transfer
        pulse_start(13'd600, 11'd4);
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_en", ram_en, 0);
        chk("t6_rst_addr", ram_addr, 0);
        chk("t6_rst_mv", m_valid, 0);
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_done", done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        snap();
        pulse_start(13'd4, 11'd1);
        wait_done(30, "t6_post_done");
        chk("t6_post_en", en_cnt - e0, 4);
        chk("t6_post_byte", rx_log[r0], 8'h4E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
